// File: rtl/wait_seq_pkg.sv
// Shared state encoding and wait-count helper for the wait sequencer.
package wait_seq_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_WAIT = 1'b1;

  // A programmed wait of zero still occupies one cycle.
  function automatic logic [31:0] eff_wait(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/wait_seq_counter.sv
// Down-counter for step dwell time; flags the final cycle of a step (cnt == 1).
module wait_seq_counter
  import wait_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic             clr,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CNT_W'(eff_wait(32'(load_val)));
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/wait_seq_thread.sv
// Multi-step wait sequencer: steps through NUM_STEPS values, each held for its wait count.
// Optional cancel support is built when WAIT_ABORT_EN is defined.
module wait_seq_thread
  import wait_seq_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_STEPS = 4,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned IDX_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_STEPS*DATA_W-1:0]   step_val,
  input  logic [NUM_STEPS*CNT_W-1:0]    step_wait,
  output logic [DATA_W-1:0]             out_val,
  output logic [IDX_W-1:0]              step_idx,
  output logic                          busy,
`ifdef WAIT_ABORT_EN
  input  logic                          abort,
  output logic                          aborted,
`endif
  output logic                          done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

  logic [DATA_W-1:0] vals  [NUM_STEPS];
  logic [CNT_W-1:0]  waits [NUM_STEPS];

  for (genvar k = 0; k < NUM_STEPS; k++) begin : g_unpack
    assign vals[k]  = step_val[k*DATA_W +: DATA_W];
    assign waits[k] = step_wait[k*CNT_W +: CNT_W];
  end

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, sel_idx;
  logic [DATA_W-1:0] out_q, out_d;
  logic              done_q, done_d;
  logic              cnt_load, cnt_dec, cnt_clr, cnt_last;
  logic [CNT_W-1:0]  cnt;
`ifdef WAIT_ABORT_EN
  logic              aborted_q, aborted_d;
`endif

  wait_seq_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .clr      (cnt_clr),
    .load_val (waits[sel_idx]),
    .cnt      (cnt),
    .last     (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    out_d    = out_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_clr  = 1'b0;
    sel_idx  = idx_q;
`ifdef WAIT_ABORT_EN
    aborted_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_WAIT;
          sel_idx  = '0;
          idx_d    = '0;
          out_d    = vals[sel_idx];
          cnt_load = 1'b1;
        end
      end
      ST_WAIT: begin
`ifdef WAIT_ABORT_EN
        // Cancel takes priority over a completion landing on the same edge.
        if (abort) begin
          state_d   = ST_IDLE;
          cnt_clr   = 1'b1;
          aborted_d = 1'b1;
        end else
`endif
        if (cnt_last) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            cnt_dec = 1'b1;
          end else begin
            sel_idx  = idx_q + 1'b1;
            idx_d    = sel_idx;
            out_d    = vals[sel_idx];
            cnt_load = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

`ifdef WAIT_ABORT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= aborted_d;
    end
  end

  assign aborted = aborted_q;
`endif

  assign out_val  = out_q;
  assign step_idx = idx_q;
  assign busy     = (state_q == ST_WAIT);
  assign done     = done_q;

endmodule

// File: tb/tb_wait_seq_thread.sv
// Scoreboard bench for wait_seq_thread; abort scenarios are exercised when WAIT_ABORT_EN is defined.
module tb_wait_seq_thread;

  localparam int DATA_W    = 32;
  localparam int NUM_STEPS = 4;
  localparam int CNT_W     = 16;
  localparam int IDX_W     = 2;

  logic                        clk = 1'b0;
  logic                        reset = 1'b0;
  logic                        start = 1'b0;
  logic [NUM_STEPS*DATA_W-1:0] step_val = '0;
  logic [NUM_STEPS*CNT_W-1:0]  step_wait = '0;
  logic [DATA_W-1:0]           out_val;
  logic [IDX_W-1:0]            step_idx;
  logic                        busy;
  logic                        done;
`ifdef WAIT_ABORT_EN
  logic                        abort = 1'b0;
  logic                        aborted;
`endif

  wait_seq_thread #(
    .DATA_W    (DATA_W),
    .NUM_STEPS (NUM_STEPS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .step_val  (step_val),
    .step_wait (step_wait),
    .out_val   (out_val),
    .step_idx  (step_idx),
    .busy      (busy),
`ifdef WAIT_ABORT_EN
    .abort     (abort),
    .aborted   (aborted),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = busy step cycle, 1 = done pulse, 2 = aborted pulse
  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] val;
    logic [IDX_W-1:0]  idx;
    int                kind;
  } exp_t;

  exp_t              q[$];
  int                n_checks = 0;
  int                n_fail = 0;
  int                nxt = 0;
  logic [DATA_W-1:0] cfg_val[NUM_STEPS];
  int                cfg_wait[NUM_STEPS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int eff(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic apply_cfg();
    for (int k = 0; k < NUM_STEPS; k++) begin
      step_val[k*DATA_W +: DATA_W] = cfg_val[k];
      step_wait[k*CNT_W +: CNT_W]  = CNT_W'(cfg_wait[k]);
    end
  endtask

  // One cycle of stimulus; the model decides acceptance and predicts the whole response trace.
  task automatic drive(input bit st, input bit ab);
    int rem;
    int c;
    int off;
    @(posedge clk);
    #2;
    c   = cyc;
    rem = nxt;
    apply_cfg();
    if (rem == 0 && st) begin
      off = 1;
      for (int k = 0; k < NUM_STEPS; k++) begin
        for (int j = 0; j < eff(cfg_wait[k]); j++) begin
          q.push_back('{c + off, cfg_val[k], IDX_W'(k), 0});
          off++;
        end
      end
      q.push_back('{c + off, cfg_val[NUM_STEPS-1], IDX_W'(NUM_STEPS - 1), 1});
      nxt = off - 1;
    end
`ifdef WAIT_ABORT_EN
    else if (rem > 0 && ab) begin
      exp_t keep[$];
      exp_t cur;
      cur = '{c, '0, '0, 0};
      foreach (q[i]) begin
        if (q[i].cyc == c) cur = q[i];
        if (q[i].cyc <= c) keep.push_back(q[i]);
      end
      keep.push_back('{c + 1, cur.val, cur.idx, 2});
      q   = keep;
      nxt = 0;
    end
`endif
    else begin
      nxt = (rem > 0) ? rem - 1 : 0;
    end
    start = st;
`ifdef WAIT_ABORT_EN
    abort = ab;
`endif
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    reset = 1'b0;
    start = 1'b0;
    q.delete();
    nxt = 0;
    repeat (n) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic set_cfg(input int w0, input int w1, input int w2, input int w3);
    cfg_val[0]  = 32'hA0A0_0001;
    cfg_val[1]  = 32'hB0B0_0002;
    cfg_val[2]  = 32'hC0C0_0003;
    cfg_val[3]  = 32'hD0D0_0004;
    cfg_wait[0] = w0;
    cfg_wait[1] = w1;
    cfg_wait[2] = w2;
    cfg_wait[3] = w3;
  endtask

  // Monitor: pops the prediction for the current cycle whenever the DUT presents an output.
  initial begin
    exp_t e;
    logic pres;
    logic abt;
    forever begin
      @(negedge clk);
      abt = 1'b0;
`ifdef WAIT_ABORT_EN
      abt = aborted;
`endif
      if (!reset) begin
        check("reset_outputs", {abt, busy, done, step_idx, out_val}, '0);
      end else begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL missed_output: expected event at cycle %0d not seen, now %0d",
                   q[0].cyc, cyc);
          void'(q.pop_front());
        end
        pres = busy | done | abt;
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          check("busy", busy, e.kind == 0);
          check("done", done, e.kind == 1);
          check("aborted", abt, e.kind == 2);
          check("out_val", out_val, e.val);
          check("step_idx", step_idx, e.idx);
        end else if (pres) begin
          check("unexpected_output", pres, 1'b0);
        end
      end
    end
  end

  initial begin
    // Reset with nonzero inputs and start requested.
    set_cfg(1, 2, 3, 4);
    apply_cfg();
    start = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    start = 1'b0;
    repeat (4) drive(0, 0);
    check("idle_out_val", out_val, '0);
    check("idle_step_idx", step_idx, '0);

    // Waits 1..4: values held 1,2,3,4 cycles, done after 10 busy cycles.
    drive(1, 0);
    repeat (13) drive(0, 0);

    // Zero waits are treated as one cycle each.
    set_cfg(0, 0, 0, 0);
    drive(1, 0);
    repeat (7) drive(0, 0);

    // Start held high: back-to-back sequences, starts during busy ignored.
    set_cfg(1, 0, 2, 3);
    repeat (30) drive(1, 0);
    repeat (10) drive(0, 0);

    // Reset during step 2 with cnt == 2, then a full run.
    set_cfg(1, 2, 3, 4);
    drive(1, 0);
    repeat (4) drive(0, 0);
    do_reset(2);
    drive(1, 0);
    repeat (13) drive(0, 0);

`ifdef WAIT_ABORT_EN
    // Abort in step 1, abort in the final cnt == 1 cycle, abort racing start in idle.
    drive(1, 0);
    drive(0, 0);
    drive(0, 1);
    repeat (4) drive(0, 0);
    drive(1, 0);
    repeat (9) drive(0, 0);
    drive(0, 1);
    repeat (4) drive(0, 0);
    drive(1, 1);
    repeat (13) drive(0, 0);
`endif

    // Randomized traffic; config only changes while the model says the DUT is idle.
    for (int i = 0; i < 500; i++) begin
      bit st;
      bit ab;
      if (nxt == 0) begin
        for (int k = 0; k < NUM_STEPS; k++) begin
          cfg_val[k]  = $urandom;
          cfg_wait[k] = $urandom_range(0, 5);
        end
      end
      st = ($urandom_range(0, 3) == 0);
      ab = 1'b0;
`ifdef WAIT_ABORT_EN
      ab = ($urandom_range(0, 11) == 0);
`endif
      drive(st, ab);
    end
    repeat (30) drive(0, 0);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
